if_fetch_ctrl: RTL and testbench

//  Sequencer for the instruction fetch stage. Owns the program counter and drives
//  the PC-select, PC-write, IF/ID-write and IF/ID-flush controls. It handles boot

---
 rtl/if_fetch_ctrl_if.sv | 33 +++
 rtl/if_fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_if_fetch_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_if.sv
// Fetch-control bundle between hazard/EX-MEM side and PC/IF-ID side.
// slave: the fetch sequencer; master: the pipeline around it.
interface if_fetch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             ex_mem_pcsrc;
  logic [31:0]      ex_mem_npc;
  logic             id_stall;
  logic [31:0]      pc;
  logic [31:0]      npc;
  logic             pc_sel;
  logic             pc_we;
  logic             if_id_we;
  logic             if_id_flush;
  logic             fetch_valid;
  logic [CNT_W-1:0] redirect_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             stall_err;

  modport master (
    output ex_mem_pcsrc, ex_mem_npc, id_stall,
    input  pc, npc, pc_sel, pc_we, if_id_we,
    input  if_id_flush, fetch_valid,
    input  redirect_cnt, stall_cnt, stall_err
  );

  modport slave (
    input  ex_mem_pcsrc, ex_mem_npc, id_stall,
    output pc, npc, pc_sel, pc_we, if_id_we,
    output if_id_flush, fetch_valid,
    output redirect_cnt, stall_cnt, stall_err
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer: owns PC, boot hold-off, stall/redirect control, counters.
// Ports: clk, rst (sync, active high), bus (if_fetch_ctrl_if.slave).
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BOOT_WAIT   = 2,
  parameter int          STALL_LIMIT = 16,
  parameter int          CNT_W       = 16
) (
  input logic            clk,
  input logic            rst,
  if_fetch_ctrl_if.slave bus
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam int BW = (BOOT_WAIT > 0) ?
                      $clog2(BOOT_WAIT + 1) : 1;
  localparam int RW = $clog2(STALL_LIMIT + 1);
  localparam logic [RW-1:0] RLIM = RW'(STALL_LIMIT);
  localparam logic [BW-1:0] BINI = BW'(BOOT_WAIT);
  // Zero boot wait skips BOOT entirely.
  localparam state_t RST_ST =
    (BOOT_WAIT == 0) ? RUN : BOOT;

  state_t           state_q;
  logic [31:0]      pc_q;
  logic [BW-1:0]    boot_ctr_q;
  logic [CNT_W-1:0] redirect_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [RW-1:0]    stall_run_q;
  logic [RW-1:0]    stall_run_d;
  logic             stall_err_q;

  logic redir, stall;
  logic pc_sel, pc_we, if_id_we;
  logic if_id_flush, fetch_valid;

  // Mealy decode; rst and BOOT share the flush-hold pattern.
  always_comb begin
    redir       = 1'b0;
    stall       = 1'b0;
    pc_sel      = 1'b0;
    pc_we       = 1'b0;
    if_id_we    = 1'b1;
    if_id_flush = 1'b1;
    fetch_valid = 1'b0;
    if (!rst && state_q == RUN) begin
      if (bus.ex_mem_pcsrc) begin
        redir  = 1'b1;
        pc_sel = 1'b1;
        pc_we  = 1'b1;
      end else if (bus.id_stall) begin
        stall       = 1'b1;
        if_id_we    = 1'b0;
        if_id_flush = 1'b0;
      end else begin
        pc_we       = 1'b1;
        if_id_flush = 1'b0;
        fetch_valid = 1'b1;
      end
    end
  end

  always_comb begin
    stall_run_d = stall_run_q;
    if (redir)
      stall_run_d = '0;
    else if (stall)
      stall_run_d = (stall_run_q == RLIM) ?
                    stall_run_q : stall_run_q + 1'b1;
    else if (state_q == RUN)
      stall_run_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RST_ST;
      pc_q           <= RESET_PC;
      boot_ctr_q     <= BINI;
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
      stall_run_q    <= '0;
      stall_err_q    <= 1'b0;
    end else begin
      stall_run_q <= stall_run_d;
      case (state_q)
        BOOT: begin
          if (boot_ctr_q != '0)
            boot_ctr_q <= boot_ctr_q - 1'b1;
          // Leave on the edge where the count hits zero.
          if (boot_ctr_q <= BW'(1))
            state_q <= RUN;
        end
        default: begin
          if (redir) begin
            pc_q <= bus.ex_mem_npc;
            if (!(&redirect_cnt_q))
              redirect_cnt_q <= redirect_cnt_q + 1'b1;
          end else if (stall) begin
            if (!(&stall_cnt_q))
              stall_cnt_q <= stall_cnt_q + 1'b1;
            if (stall_run_d == RLIM)
              stall_err_q <= 1'b1;
          end else begin
            pc_q <= pc_q + 32'd4;
          end
        end
      endcase
    end
  end

  assign bus.pc           = pc_q;
  assign bus.npc          = pc_q + 32'd4;
  assign bus.pc_sel       = pc_sel;
  assign bus.pc_we        = pc_we;
  assign bus.if_id_we     = if_id_we;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.fetch_valid  = fetch_valid;
  assign bus.redirect_cnt = redirect_cnt_q;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.stall_err    = stall_err_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a scoreboard queue.
// Narrow counters (CNT_W=4) so saturation is reached quickly.
module tb_if_fetch_ctrl;

  localparam int CW = 4;
  localparam int LIM = 16;
  localparam int BWAIT = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  // {pc_sel, pc_we, if_id_we, if_id_flush, fetch_valid}
  localparam logic [4:0] C_BOOT  = 5'b00110;
  localparam logic [4:0] C_NORM  = 5'b01101;
  localparam logic [4:0] C_RED   = 5'b11110;
  localparam logic [4:0] C_STALL = 5'b00000;

  typedef struct {
    string         tag;
    logic          full;
    logic [31:0]   pc;
    logic [4:0]    ctl;
    logic [CW-1:0] rc;
    logic [CW-1:0] sc;
    logic          err;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  exp_t sbq[$];

  logic          m_init;
  logic [31:0]   m_pc;
  int            m_boot;
  logic [CW-1:0] m_rc;
  logic [CW-1:0] m_sc;
  int            m_run;
  logic          m_err;

  if_fetch_ctrl_if #(.CNT_W(CW)) bus ();

  if_fetch_ctrl #(
    .RESET_PC(RPC),
    .BOOT_WAIT(BWAIT),
    .STALL_LIMIT(LIM),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step(string tag, logic r, logic ps,
                      logic [31:0] np, logic st);
    exp_t e;
    exp_t g;
    rst = r;
    bus.ex_mem_pcsrc = ps;
    bus.ex_mem_npc = np;
    bus.id_stall = st;
    e.tag = tag;
    e.full = m_init;
    e.pc = m_pc;
    e.rc = m_rc;
    e.sc = m_sc;
    e.err = m_err;
    if (r || m_boot > 0) e.ctl = C_BOOT;
    else if (ps) e.ctl = C_RED;
    else if (st) e.ctl = C_STALL;
    else e.ctl = C_NORM;
    sbq.push_back(e);
    if (r) begin
      m_init = 1'b1;
      m_pc = RPC;
      m_boot = BWAIT;
      m_rc = '0;
      m_sc = '0;
      m_run = 0;
      m_err = 1'b0;
    end else if (m_boot > 0) begin
      m_boot--;
    end else if (ps) begin
      m_pc = np;
      if (m_rc != {CW{1'b1}}) m_rc++;
      m_run = 0;
    end else if (st) begin
      if (m_sc != {CW{1'b1}}) m_sc++;
      if (m_run < LIM) m_run++;
      if (m_run == LIM) m_err = 1'b1;
    end else begin
      m_pc = m_pc + 32'd4;
      m_run = 0;
    end
    #3;
    g = sbq.pop_front();
    chk({g.tag, ".ctl"}, 32'({bus.pc_sel, bus.pc_we,
        bus.if_id_we, bus.if_id_flush,
        bus.fetch_valid}), 32'(g.ctl));
    if (g.full) begin
      chk({g.tag, ".pc"}, bus.pc, g.pc);
      chk({g.tag, ".npc"}, bus.npc, g.pc + 32'd4);
      chk({g.tag, ".rcnt"}, 32'(bus.redirect_cnt),
          32'(g.rc));
      chk({g.tag, ".scnt"}, 32'(bus.stall_cnt),
          32'(g.sc));
      chk({g.tag, ".err"}, 32'(bus.stall_err),
          32'(g.err));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    m_init = 1'b0;
    m_pc = '0;
    m_boot = 0;
    m_rc = '0;
    m_sc = '0;
    m_run = 0;
    m_err = 1'b0;
    rst = 1'b1;
    bus.ex_mem_pcsrc = 1'b0;
    bus.ex_mem_npc = '0;
    bus.id_stall = 1'b0;
    #1;
    // boot and first fetches
    step("rst", 1, 0, 0, 0);
    step("boot0", 0, 0, 0, 0);
    step("boot1", 0, 0, 0, 0);
    step("run0", 0, 0, 0, 0);
    step("run4", 0, 0, 0, 0);
    step("run8", 0, 0, 0, 0);
    step("runC", 0, 0, 0, 0);
    // redirect at 0x10
    step("red40", 0, 1, 32'h40, 0);
    step("at40", 0, 0, 0, 0);
    // load-use stall at 0x20
    step("red20", 0, 1, 32'h20, 0);
    for (int i = 0; i < 3; i++)
      step($sformatf("stl%0d", i), 0, 0, 0, 1);
    step("at20", 0, 0, 0, 0);
    step("at24", 0, 0, 0, 0);
    // redirect beats stall
    step("both", 0, 1, 32'h80, 1);
    step("at80", 0, 0, 0, 0);
    // redirect clears the stall run
    for (int i = 0; i < 10; i++)
      step($sformatf("sa%0d", i), 0, 0, 0, 1);
    step("bothB", 0, 1, 32'h102, 1);
    for (int i = 0; i < 10; i++)
      step($sformatf("sb%0d", i), 0, 0, 0, 1);
    step("at102", 0, 0, 0, 0);
    // watchdog trips on the 16th edge
    for (int i = 0; i < LIM + 2; i++)
      step($sformatf("wd%0d", i), 0, 0, 0, 1);
    step("wdn0", 0, 0, 0, 0);
    step("wdn1", 0, 0, 0, 0);
    // pc wrap
    step("redtop", 0, 1, 32'hFFFF_FFFC, 0);
    step("attop", 0, 0, 0, 0);
    step("wrap0", 0, 0, 0, 0);
    // redirect counter saturation
    for (int i = 0; i < 12; i++)
      step($sformatf("rs%0d", i), 0, 1,
           32'h1000 + 32'(i * 8), 0);
    step("rsn", 0, 0, 0, 0);
    // reset mid-stall, inputs ignored in BOOT
    step("ms0", 0, 0, 0, 1);
    step("ms1", 0, 0, 0, 1);
    step("rst2", 1, 1, 32'h200, 1);
    step("boot2", 0, 1, 32'h300, 1);
    step("boot3", 0, 0, 0, 1);
    step("rrun0", 0, 0, 0, 0);
    step("rrun4", 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
